// File: rtl/noise_gate_pkg.sv
// ---------------------------------------------------------------------------
// noise_gate_pkg : shared types, constants and arithmetic helpers
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package noise_gate_pkg;

  localparam int GAIN_W   = 9;
  localparam int SAMPLE_W = 32;
  localparam logic [GAIN_W-1:0] GAIN_ONE = 9'd256;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_t;

  // Magnitude of a two's-complement sample; the most negative value clips to max positive.
  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    if (x == 32'h8000_0000) begin
      return 32'h7FFF_FFFF;
    end else if (x[SAMPLE_W-1]) begin
      return (~x) + 32'd1;
    end else begin
      return x;
    end
  endfunction

  function automatic logic [SAMPLE_W-1:0] apply_gain(input logic [SAMPLE_W-1:0] s,
                                                     input logic [GAIN_W-1:0]   g);
    logic signed [40:0] p;
    p = $signed({{9{s[SAMPLE_W-1]}}, s}) * $signed({32'b0, g});
    return 32'(p >>> 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_envelope.sv
// ---------------------------------------------------------------------------
// gate_envelope : stereo peak detector with exponential decay
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_envelope
  import noise_gate_pkg::*;
#(
  parameter int DECAY_SHIFT = 6
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_L,
  input  logic [SAMPLE_W-1:0] in_R,
  output logic [SAMPLE_W-1:0] env,
  output logic                env_valid
);

  logic [SAMPLE_W-1:0] abs_L, abs_R, peak;
  logic [SAMPLE_W-1:0] env_q;
  logic                valid_q;

  assign abs_L = sat_abs(in_L);
  assign abs_R = sat_abs(in_R);
  assign peak  = (abs_L > abs_R) ? abs_L : abs_R;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      env_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        env_q <= (peak > env_q) ? peak : env_q - (env_q >> DECAY_SHIFT);
      end
    end
  end

  assign env       = env_q;
  assign env_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/noise_gate.sv
// ---------------------------------------------------------------------------
// noise_gate : stereo noise gate, shared envelope drives a ramped gain FSM
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module noise_gate
  import noise_gate_pkg::*;
#(
  parameter logic [31:0] OPEN_THRESH  = 32'd2000000,
  parameter logic [31:0] CLOSE_THRESH = 32'd1000000,
  parameter int          HOLD_SAMPLES = 2400,
  parameter int          ATTACK_STEP  = 32,
  parameter int          RELEASE_STEP = 1,
  parameter int          DECAY_SHIFT  = 6
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_L,
  input  logic [SAMPLE_W-1:0] in_R,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_L,
  output logic [SAMPLE_W-1:0] out_R,
  output logic                gate_open
);

  localparam int CNT_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_SAMPLES - 1);

  logic [SAMPLE_W-1:0] env;
  logic                v1;
  logic [SAMPLE_W-1:0] s1_L_q, s1_R_q, s2_L_q, s2_R_q, out_L_q, out_R_q;
  logic                v2_q, out_valid_q;

  gate_state_t         state_q, state_d;
  logic [GAIN_W-1:0]   gain_q, gain_d, gain_up, gain_dn;
  logic [GAIN_W:0]     gain_sum;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                env_hi, env_lo;

  gate_envelope #(
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_env (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_L     (in_L),
    .in_R     (in_R),
    .env      (env),
    .env_valid(v1)
  );

  assign env_hi   = (env >= OPEN_THRESH);
  assign env_lo   = (env <  CLOSE_THRESH);
  assign gain_sum = {1'b0, gain_q} + (GAIN_W+1)'(ATTACK_STEP);
  assign gain_up  = (gain_sum >= {1'b0, GAIN_ONE}) ? GAIN_ONE : gain_sum[GAIN_W-1:0];
  assign gain_dn  = (gain_q <= GAIN_W'(RELEASE_STEP)) ? '0 : gain_q - GAIN_W'(RELEASE_STEP);

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      // Bypass parks the gate fully open so re-enabling is click-free.
      state_d = OPEN;
      gain_d  = GAIN_ONE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CLOSED: begin
          if (env_hi) begin
            state_d = ATTACK;
            gain_d  = gain_up;
          end
        end
        ATTACK: begin
          gain_d = gain_up;
          if (gain_up == GAIN_ONE) state_d = OPEN;
        end
        OPEN: begin
          if (env_lo) begin
            state_d = HOLD;
            cnt_d   = HOLD_INIT;
          end
        end
        HOLD: begin
          if (env_hi)              state_d = OPEN;
          else if (cnt_q == '0)    state_d = RELEASE;
          else                     cnt_d   = cnt_q - CNT_W'(1);
        end
        RELEASE: begin
          if (env_hi) begin
            state_d = ATTACK;
            gain_d  = gain_up;
          end else begin
            gain_d = gain_dn;
            if (gain_dn == '0) state_d = CLOSED;
          end
        end
        default: state_d = CLOSED;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLOSED;
      gain_q  <= '0;
      cnt_q   <= '0;
    end else if (v1) begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_L_q      <= '0;
      s1_R_q      <= '0;
      s2_L_q      <= '0;
      s2_R_q      <= '0;
      v2_q        <= 1'b0;
      out_L_q     <= '0;
      out_R_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (in_valid) begin
        s1_L_q <= in_L;
        s1_R_q <= in_R;
      end
      if (v1) begin
        s2_L_q <= s1_L_q;
        s2_R_q <= s1_R_q;
      end
      v2_q <= v1;
      // gain_q already holds the value computed from this sample's own envelope.
      if (v2_q) begin
        out_L_q <= apply_gain(s2_L_q, gain_q);
        out_R_q <= apply_gain(s2_R_q, gain_q);
      end
      out_valid_q <= v2_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_L     = out_L_q;
  assign out_R     = out_R_q;
  assign gate_open = (state_q == ATTACK) || (state_q == OPEN) || (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_noise_gate.sv
// ---------------------------------------------------------------------------
// tb_noise_gate : directed self-checking bench for noise_gate
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_noise_gate;

  logic               CLOCK_50;
  logic               resetn;
  logic               enable;
  logic               in_valid;
  logic signed [31:0] in_L, in_R;
  logic               out_valid;
  logic signed [31:0] out_L, out_R;
  logic               gate_open;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] env_m = 32'd0;

  noise_gate #(
    .HOLD_SAMPLES(4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .enable   (enable),
    .in_valid (in_valid),
    .in_L     (in_L),
    .in_R     (in_R),
    .out_valid(out_valid),
    .out_L    (out_L),
    .out_R    (out_R),
    .gate_open(gate_open)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_abs(input logic [31:0] x);
    if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    if ($signed(x) < 0)     return 32'(-$signed(x));
    return x;
  endfunction

  function automatic logic [31:0] m_env(input logic [31:0] e, input logic [31:0] l, input logic [31:0] r);
    logic [31:0] a;
    a = (m_abs(l) > m_abs(r)) ? m_abs(l) : m_abs(r);
    return (a > e) ? a : e - (e >> 6);
  endfunction

  // One isolated sample: four cycles, exact three-stage latency checked.
  task automatic do_sample(input logic signed [31:0] l, input logic signed [31:0] r,
                           input logic signed [31:0] el, input logic signed [31:0] er,
                           input logic eo, input string tag);
    @(negedge CLOCK_50);
    in_valid = 1'b1; in_L = l; in_R = r;
    env_m = m_env(env_m, l, r);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    @(negedge CLOCK_50);
    chk({tag, "_early"}, out_valid, 0);
    @(negedge CLOCK_50);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_L"}, out_L, el);
    chk({tag, "_R"}, out_R, er);
    chk({tag, "_open"}, gate_open, eo);
  endtask

  // Feeds 256000 on both channels: out = 1000*gain, so the gain ramp is visible.
  task automatic run_gate(input int stop_k, input string tag);
    int k = -1;
    int g;
    logic [31:0] nxt;
    for (int i = 0; i < 1000; i++) begin
      nxt = m_env(env_m, 32'd256000, 32'd256000);
      if (k >= 0) k++;
      else if (nxt < 32'd1000000) k = 0;
      if (k <= 4)             g = 256;
      else if (k - 4 >= 256)  g = 0;
      else                    g = 256 - (k - 4);
      do_sample(256000, 256000, 1000 * g, 1000 * g, (k <= 3), $sformatf("%s_k%0d", tag, k));
      if (k == stop_k) break;
    end
  endtask

  logic signed [31:0] vl [4];
  logic signed [31:0] vr [4];

  initial begin
    resetn = 1'b1; enable = 1'b1; in_valid = 1'b0; in_L = '0; in_R = '0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_L", out_L, 0);
    chk("rst_R", out_R, 0);
    chk("rst_open", gate_open, 0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;

    // Below threshold: gate stays closed, gain 0.
    do_sample( 500000, -500000, 0, 0, 1'b0, "low0");
    do_sample(-500000,  500000, 0, 0, 1'b0, "low1");
    do_sample( 500000,  500000, 0, 0, 1'b0, "low2");
    do_sample(-500000, -500000, 0, 0, 1'b0, "low3");

    // Attack ramp: 32 per sample.
    for (int i = 1; i <= 8; i++)
      do_sample(5000000, 5000000, 625000 * i, 625000 * i, 1'b1, $sformatf("atk%0d", i));

    // Decay through hold and full release to closed.
    run_gate(262, "rel");

    // Reopen, release to gain 100, then re-trigger.
    for (int i = 1; i <= 8; i++)
      do_sample(5000000, 5000000, 625000 * i, 625000 * i, 1'b1, $sformatf("reatk%0d", i));
    run_gate(160, "rel2");
    do_sample(3000000, 3000000, 1546875, 1546875, 1'b1, "trig132");
    do_sample(3000000, 3000000, 1921875, 1921875, 1'b1, "trig164");
    do_sample(3000000, 3000000, 2296875, 2296875, 1'b1, "trig196");
    do_sample(3000000, 3000000, 2671875, 2671875, 1'b1, "trig228");
    do_sample(3000000, 3000000, 3000000, 3000000, 1'b1, "trig256");
    do_sample(3000000, 3000000, 3000000, 3000000, 1'b1, "trigopen");

    // Bypass, back-to-back edge values.
    vl[0] = 32'sh8000_0000; vl[1] = 32'sh7FFF_FFFF; vl[2] = -32'sd1;        vl[3] = 32'sd0;
    vr[0] = 32'sd0;         vr[1] = -32'sd1;        vr[2] = 32'sh7FFF_FFFF; vr[3] = 32'sh8000_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK_50);
      if (i == 0) enable = 1'b0;
      if (i == 2) chk("byp_early", out_valid, 0);
      if (i >= 3 && i <= 6) begin
        chk($sformatf("byp%0d_valid", i - 3), out_valid, 1);
        chk($sformatf("byp%0d_L", i - 3), out_L, vl[i - 3]);
        chk($sformatf("byp%0d_R", i - 3), out_R, vr[i - 3]);
        chk($sformatf("byp%0d_open", i - 3), gate_open, 1);
      end
      if (i == 7) chk("byp_end", out_valid, 0);
      if (i < 4) begin
        in_valid = 1'b1; in_L = vl[i]; in_R = vr[i];
        env_m = m_env(env_m, vl[i], vr[i]);
      end else begin
        in_valid = 1'b0;
      end
    end

    enable = 1'b1;
    do_sample(32'sh8000_0000, 32'sh7FFF_FFFF, 32'sh8000_0000, 32'sh7FFF_FFFF, 1'b1, "unity");

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      if (i == 3) begin
        chk("mid_valid", out_valid, 1);
        chk("mid_L", out_L, 1234567);
      end
      in_valid = 1'b1; in_L = 1234567; in_R = -1234567;
    end
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_L", out_L, 0);
    chk("arst_R", out_R, 0);
    chk("arst_open", gate_open, 0);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      chk($sformatf("drop%0d", i), out_valid, 0);
    end
    chk("post_open", gate_open, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
